// File: rtl/motor_step_decoder.sv
// Step/direction decoder: synchronizes step_in/dir_in and tracks a signed position.
// It also checks setup, pulse-width and gap timing, with one-cycle and sticky error reporting.
module motor_step_decoder #(
  parameter int X_BITS = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_in,
  input  logic                     dir_in,
  input  logic                     invert_dir,
  input  logic [31:0]              setup_n,
  input  logic [31:0]              pulse_n,
  input  logic [31:0]              gap_n,
  output logic                     step_stb,
  output logic                     step_dir,
  output logic                     err_setup,
  output logic                     err_pulse,
  output logic                     err_gap,
  output logic [2:0]               err_flags,
  input  logic                     clr_err,
  input  logic                     set_x,
  input  logic signed [X_BITS-1:0] x_val,
  output logic signed [X_BITS-1:0] x,
  input  logic                     hold,
  output logic signed [X_BITS-1:0] x_hold
);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  localparam int CHK_SETUP = 0;
  localparam int CHK_PULSE = 1;
  localparam int CHK_GAP   = 2;

  state_t state_q, state_d;

  // Bit 0 = s1, bit 1 = s2, bit 2 = s3.
  logic [2:0] step_sync_q;
  logic [2:0] dir_sync_q;
  // Marks which synchronizer stages hold a genuine sample rather than a reset value.
  logic [2:0] sync_vld_q;

  logic [15:0] dir_age_q, dir_age_d;
  logic [15:0] high_cnt_q, high_cnt_d;
  logic [15:0] low_cnt_q, low_cnt_d;

  logic signed [X_BITS-1:0] x_q, x_d;
  logic signed [X_BITS-1:0] x_hold_q, x_hold_d;

  logic       step_stb_q, step_stb_d;
  logic       step_dir_q, step_dir_d;
  logic [2:0] err_q, err_d;
  logic [2:0] err_flags_q, err_flags_d;

  logic        rise;
  logic        fall;
  logic        dir_chg;
  logic        dir_dec;
  logic [15:0] age_eff;

  logic [15:0] chk_val [3];
  logic [15:0] chk_thr [3];
  logic [2:0]  chk_short;

  logic unused_hi_bits;
  assign unused_hi_bits = ^{setup_n[31:16], pulse_n[31:16], gap_n[31:16]};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Edges are only trusted once s3 holds a real sample, so a line already
  // high when reset is released does not look like a fresh rise.
  assign rise    = sync_vld_q[2] & step_sync_q[1] & ~step_sync_q[2] & (state_q == ST_LOW);
  assign fall    = sync_vld_q[2] & ~step_sync_q[1] & step_sync_q[2] & (state_q == ST_HIGH);
  assign dir_chg = sync_vld_q[2] & (dir_sync_q[1] ^ dir_sync_q[2]);
  assign dir_dec = dir_sync_q[1] ^ invert_dir;
  assign age_eff = dir_chg ? 16'd0 : dir_age_q;

  assign chk_val[CHK_SETUP] = age_eff;
  assign chk_val[CHK_PULSE] = high_cnt_q;
  assign chk_val[CHK_GAP]   = low_cnt_q;
  assign chk_thr[CHK_SETUP] = setup_n[15:0];
  assign chk_thr[CHK_PULSE] = pulse_n[15:0];
  assign chk_thr[CHK_GAP]   = gap_n[15:0];

  // A zero threshold disables its check.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chk
    assign chk_short[gi] = (chk_thr[gi] != 16'd0) && (chk_val[gi] < chk_thr[gi]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOW:  if (rise) state_d = ST_HIGH;
      ST_HIGH: if (fall) state_d = ST_LOW;
      default: state_d = ST_LOW;
    endcase
  end

  always_comb begin
    dir_age_d  = dir_chg ? 16'd0 : sat_inc(dir_age_q);

    high_cnt_d = high_cnt_q;
    if (rise) begin
      high_cnt_d = 16'd1;
    end else if (state_q == ST_HIGH) begin
      high_cnt_d = sat_inc(high_cnt_q);
    end

    low_cnt_d = low_cnt_q;
    if (fall) begin
      low_cnt_d = 16'd1;
    end else if (state_q == ST_LOW) begin
      low_cnt_d = sat_inc(low_cnt_q);
    end

    x_d = x_q;
    if (set_x) begin
      x_d = x_val;
    end else if (rise) begin
      x_d = dir_dec ? x_q - X_BITS'(1) : x_q + X_BITS'(1);
    end

    x_hold_d   = hold ? x_q : x_hold_q;
    step_stb_d = rise;
    step_dir_d = dir_dec;

    // Direction must stay put for the whole high phase, so a change there is a setup fault.
    err_d[CHK_SETUP] = (rise & chk_short[CHK_SETUP]) | ((state_q == ST_HIGH) & dir_chg);
    err_d[CHK_PULSE] = fall & chk_short[CHK_PULSE];
    err_d[CHK_GAP]   = rise & chk_short[CHK_GAP];

    err_flags_d = (clr_err ? 3'b000 : err_flags_q) | err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOW;
      step_sync_q <= 3'b000;
      dir_sync_q  <= 3'b000;
      sync_vld_q  <= 3'b000;
      dir_age_q   <= 16'hFFFF;
      high_cnt_q  <= 16'd0;
      low_cnt_q   <= 16'hFFFF;
      x_q         <= '0;
      x_hold_q    <= '0;
      step_stb_q  <= 1'b0;
      step_dir_q  <= 1'b0;
      err_q       <= 3'b000;
      err_flags_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      step_sync_q <= {step_sync_q[1:0], step_in};
      dir_sync_q  <= {dir_sync_q[1:0], dir_in};
      sync_vld_q  <= {sync_vld_q[1:0], 1'b1};
      dir_age_q   <= dir_age_d;
      high_cnt_q  <= high_cnt_d;
      low_cnt_q   <= low_cnt_d;
      x_q         <= x_d;
      x_hold_q    <= x_hold_d;
      step_stb_q  <= step_stb_d;
      step_dir_q  <= step_dir_d;
      err_q       <= err_d;
      err_flags_q <= err_flags_d;
    end
  end

  assign step_stb  = step_stb_q;
  assign step_dir  = step_dir_q;
  assign err_setup = err_q[CHK_SETUP];
  assign err_pulse = err_q[CHK_PULSE];
  assign err_gap   = err_q[CHK_GAP];
  assign err_flags = err_flags_q;
  assign x         = x_q;
  assign x_hold    = x_hold_q;

endmodule

// File: tb/tb_motor_step_decoder.sv
// Directed testbench for motor_step_decoder: one task per scenario, inline checks,
// inputs driven and outputs sampled on the falling clock edge.
module tb_motor_step_decoder;

  localparam int XB = 24;

  logic                 clk;
  logic                 reset;
  logic                 step_in;
  logic                 dir_in;
  logic                 invert_dir;
  logic [31:0]          setup_n;
  logic [31:0]          pulse_n;
  logic [31:0]          gap_n;
  logic                 step_stb;
  logic                 step_dir;
  logic                 err_setup;
  logic                 err_pulse;
  logic                 err_gap;
  logic [2:0]           err_flags;
  logic                 clr_err;
  logic                 set_x;
  logic signed [XB-1:0] x_val;
  logic signed [XB-1:0] x;
  logic                 hold;
  logic signed [XB-1:0] x_hold;

  int checks   = 0;
  int failures = 0;

  int cyc, stb_cnt, stb_at, stb_dir, eset_cnt, eset_stb, epul_cnt, epul_at, egap_cnt;
  logic signed [XB-1:0] exp_x;

  motor_step_decoder #(.X_BITS(XB)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .invert_dir(invert_dir), .setup_n(setup_n), .pulse_n(pulse_n), .gap_n(gap_n),
    .step_stb(step_stb), .step_dir(step_dir), .err_setup(err_setup),
    .err_pulse(err_pulse), .err_gap(err_gap), .err_flags(err_flags),
    .clr_err(clr_err), .set_x(set_x), .x_val(x_val), .x(x),
    .hold(hold), .x_hold(x_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_counts();
    cyc = 0; stb_cnt = 0; stb_at = -1; stb_dir = -1;
    eset_cnt = 0; eset_stb = 0; epul_cnt = 0; epul_at = -1; egap_cnt = 0;
  endtask

  task automatic prepare();
    step_in = 0; dir_in = 0; invert_dir = 0;
    setup_n = 4; pulse_n = 4; gap_n = 4;
    clr_err = 0; set_x = 0; x_val = '0; hold = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    clear_counts();
  endtask

  // Drives step_in high for high_n cycles then low for low_n cycles,
  // optionally toggling dir_in at index tog_at, and tallies output strobes.
  task automatic run_pulse(input int high_n, input int low_n, input int tog_at);
    for (int i = 0; i < high_n + low_n; i++) begin
      step_in = (i < high_n);
      if (i == tog_at) dir_in = ~dir_in;
      @(negedge clk);
      cyc++;
      if (step_stb) begin
        stb_cnt++;
        if (stb_at < 0) begin
          stb_at  = cyc;
          stb_dir = int'(step_dir);
        end
      end
      if (err_setup) begin
        eset_cnt++;
        if (step_stb) eset_stb++;
      end
      if (err_pulse) begin
        epul_cnt++;
        if (epul_at < 0) epul_at = cyc;
      end
      if (err_gap) egap_cnt++;
    end
  endtask

  task automatic test_reset();
    step_in = 0; dir_in = 0; invert_dir = 0;
    setup_n = 4; pulse_n = 4; gap_n = 4;
    set_x = 1; x_val = 77; hold = 1; clr_err = 1;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++; if (x !== '0) begin failures++; $display("FAIL reset_x_in_reset got=%0d exp=0", x); end
    reset = 0; set_x = 0; hold = 0; clr_err = 0;
    @(negedge clk);
    checks++; if (x !== '0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x); end
    checks++; if (x_hold !== '0) begin failures++; $display("FAIL reset_x_hold got=%0d exp=0", x_hold); end
    checks++; if (step_stb !== 1'b0 || step_dir !== 1'b0) begin failures++; $display("FAIL reset_stb_dir got=%b%b exp=00", step_stb, step_dir); end
    checks++; if ({err_setup, err_pulse, err_gap} !== 3'b000) begin failures++; $display("FAIL reset_err got=%b exp=000", {err_setup, err_pulse, err_gap}); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", err_flags); end
    $display("test_reset: x=%0d x_hold=%0d flags=%b", x, x_hold, err_flags);
  endtask

  task automatic test_basic();
    prepare();
    run_pulse(6, 8, -1);
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL basic_stb_cnt got=%0d exp=1", stb_cnt); end
    checks++; if (stb_at != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", stb_at); end
    checks++; if (stb_dir != 0) begin failures++; $display("FAIL basic_dir got=%0d exp=0", stb_dir); end
    exp_x = 1;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL basic_x got=%0d exp=%0d", x, exp_x); end
    checks++; if (eset_cnt + epul_cnt + egap_cnt != 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", eset_cnt + epul_cnt + egap_cnt); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b exp=000", err_flags); end
    $display("test_basic: stb=%0d at=%0d x=%0d flags=%b", stb_cnt, stb_at, x, err_flags);
  endtask

  task automatic test_invert();
    prepare();
    dir_in = 1; invert_dir = 1;
    repeat (10) @(negedge clk);
    clear_counts();
    run_pulse(6, 8, -1);
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL invert_stb_cnt got=%0d exp=1", stb_cnt); end
    checks++; if (stb_dir != 0) begin failures++; $display("FAIL invert_dir got=%0d exp=0", stb_dir); end
    exp_x = 1;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL invert_x got=%0d exp=%0d", x, exp_x); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL invert_flags got=%b exp=000", err_flags); end
    $display("test_invert: stb=%0d dir=%0d x=%0d", stb_cnt, stb_dir, x);
  endtask

  task automatic test_setup_err();
    prepare();
    setup_n = 5;
    dir_in = 1;
    repeat (2) @(negedge clk);
    run_pulse(6, 8, -1);
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL setup_stb_cnt got=%0d exp=1", stb_cnt); end
    checks++; if (eset_cnt != 1 || eset_stb != 1) begin failures++; $display("FAIL setup_strobe got=%0d/%0d exp=1/1", eset_cnt, eset_stb); end
    checks++; if (err_flags !== 3'b001) begin failures++; $display("FAIL setup_flags got=%b exp=001", err_flags); end
    exp_x = -1;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL setup_x got=%0d exp=%0d", x, exp_x); end
    checks++; if (stb_dir != 1) begin failures++; $display("FAIL setup_dir got=%0d exp=1", stb_dir); end
    $display("test_setup_err: stb=%0d eset=%0d x=%0d flags=%b", stb_cnt, eset_cnt, x, err_flags);
  endtask

  task automatic test_dir_in_high();
    prepare();
    run_pulse(8, 8, 4);
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL dirhigh_stb_cnt got=%0d exp=1", stb_cnt); end
    checks++; if (eset_cnt != 1 || eset_stb != 0) begin failures++; $display("FAIL dirhigh_strobe got=%0d/%0d exp=1/0", eset_cnt, eset_stb); end
    checks++; if (err_flags !== 3'b001) begin failures++; $display("FAIL dirhigh_flags got=%b exp=001", err_flags); end
    exp_x = 1;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL dirhigh_x got=%0d exp=%0d", x, exp_x); end
    $display("test_dir_in_high: eset=%0d x=%0d flags=%b", eset_cnt, x, err_flags);
  endtask

  task automatic test_pulse_err();
    prepare();
    run_pulse(2, 10, -1);
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL pulse_stb_cnt got=%0d exp=1", stb_cnt); end
    checks++; if (epul_cnt != 1) begin failures++; $display("FAIL pulse_cnt got=%0d exp=1", epul_cnt); end
    checks++; if (epul_at != 5) begin failures++; $display("FAIL pulse_at got=%0d exp=5", epul_at); end
    checks++; if (err_flags !== 3'b010) begin failures++; $display("FAIL pulse_flags got=%b exp=010", err_flags); end
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    @(negedge clk);
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL pulse_clr got=%b exp=000", err_flags); end
    $display("test_pulse_err: epul=%0d at=%0d flags_after_clr=%b", epul_cnt, epul_at, err_flags);
  endtask

  task automatic test_gap_err();
    prepare();
    run_pulse(6, 2, -1);
    run_pulse(6, 8, -1);
    checks++; if (stb_cnt != 2) begin failures++; $display("FAIL gap_stb_cnt got=%0d exp=2", stb_cnt); end
    checks++; if (egap_cnt != 1 || eset_cnt != 0 || epul_cnt != 0) begin failures++; $display("FAIL gap_strobes got=%0d/%0d/%0d exp=1/0/0", egap_cnt, eset_cnt, epul_cnt); end
    checks++; if (err_flags !== 3'b100) begin failures++; $display("FAIL gap_flags got=%b exp=100", err_flags); end
    exp_x = 2;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL gap_x got=%0d exp=%0d", x, exp_x); end
    $display("test_gap_err: stb=%0d egap=%0d x=%0d flags=%b", stb_cnt, egap_cnt, x, err_flags);
  endtask

  task automatic test_disabled();
    prepare();
    setup_n = 0; pulse_n = 0; gap_n = 0;
    dir_in = 1;
    run_pulse(1, 1, -1);
    run_pulse(1, 8, -1);
    checks++; if (stb_cnt != 2) begin failures++; $display("FAIL disabled_stb_cnt got=%0d exp=2", stb_cnt); end
    checks++; if (eset_cnt + epul_cnt + egap_cnt != 0) begin failures++; $display("FAIL disabled_err got=%0d exp=0", eset_cnt + epul_cnt + egap_cnt); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL disabled_flags got=%b exp=000", err_flags); end
    exp_x = -2;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL disabled_x got=%0d exp=%0d", x, exp_x); end
    $display("test_disabled: stb=%0d x=%0d flags=%b", stb_cnt, x, err_flags);
  endtask

  task automatic test_set_hold();
    prepare();
    set_x = 1; x_val = -1;
    @(negedge clk);
    set_x = 0;
    exp_x = -1;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL sethold_load got=%0d exp=%0d", x, exp_x); end
    step_in = 1;
    repeat (2) @(negedge clk);
    set_x = 1; x_val = 100; hold = 1;
    @(negedge clk);
    set_x = 0; hold = 0;
    checks++; if (step_stb !== 1'b1) begin failures++; $display("FAIL sethold_stb got=%b exp=1", step_stb); end
    exp_x = 100;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL sethold_x got=%0d exp=%0d", x, exp_x); end
    exp_x = -1;
    checks++; if (x_hold !== exp_x) begin failures++; $display("FAIL sethold_hold got=%0d exp=%0d", x_hold, exp_x); end
    repeat (4) @(negedge clk);
    step_in = 0;
    repeat (6) @(negedge clk);
    exp_x = 100;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL sethold_x_after got=%0d exp=%0d", x, exp_x); end
    $display("test_set_hold: x=%0d x_hold=%0d", x, x_hold);
  endtask

  task automatic test_wrap();
    prepare();
    set_x = 1; x_val = {1'b0, {(XB-1){1'b1}}};
    @(negedge clk);
    set_x = 0;
    run_pulse(6, 8, -1);
    exp_x = {1'b1, {(XB-1){1'b0}}};
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL wrap_stb_cnt got=%0d exp=1", stb_cnt); end
    checks++; if (x !== exp_x) begin failures++; $display("FAIL wrap_x got=%0d exp=%0d", x, exp_x); end
    $display("test_wrap: x=%0d", x);
  endtask

  task automatic test_reset_step_high();
    prepare();
    step_in = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    clear_counts();
    run_pulse(10, 6, -1);
    checks++; if (stb_cnt != 0) begin failures++; $display("FAIL rsthigh_stb got=%0d exp=0", stb_cnt); end
    checks++; if (eset_cnt + epul_cnt + egap_cnt != 0) begin failures++; $display("FAIL rsthigh_err got=%0d exp=0", eset_cnt + epul_cnt + egap_cnt); end
    run_pulse(6, 8, -1);
    checks++; if (stb_cnt != 1) begin failures++; $display("FAIL rsthigh_new_stb got=%0d exp=1", stb_cnt); end
    exp_x = 1;
    checks++; if (x !== exp_x) begin failures++; $display("FAIL rsthigh_x got=%0d exp=%0d", x, exp_x); end
    checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL rsthigh_flags got=%b exp=000", err_flags); end
    $display("test_reset_step_high: stb=%0d x=%0d", stb_cnt, x);
  endtask

  initial begin
    reset = 1; step_in = 0; dir_in = 0; invert_dir = 0;
    setup_n = 4; pulse_n = 4; gap_n = 4;
    clr_err = 0; set_x = 0; x_val = '0; hold = 0;
    clear_counts();
    test_reset();
    test_basic();
    test_invert();
    test_setup_err();
    test_dir_in_high();
    test_pulse_err();
    test_gap_err();
    test_disabled();
    test_set_hold();
    test_wrap();
    test_reset_step_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_step_decoder.md
MOTOR_STEP_DECODER -- requirements
Module: motor_step_decoder

Interface
REQ-001 Parameter X_BITS, default 24, width of position counter and load value.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 step_in  input  1  external step line, asynchronous to clk.
REQ-005 dir_in  input  1  external direction line, asynchronous to clk.
REQ-006 invert_dir  input  1  XORed with synchronized dir_in to form step_dir.
REQ-007 setup_n  input  32  minimum dir-stable cycles before step rise; bits [15:0] used.
REQ-008 pulse_n  input  32  minimum step-high cycles; bits [15:0] used.
REQ-009 gap_n  input  32  minimum step-low cycles between pulses; bits [15:0] used.
REQ-010 step_stb  output  1  one-cycle strobe per accepted step rising edge.
REQ-011 step_dir  output  1  decoded direction, valid with step_stb.
REQ-012 err_setup / err_pulse / err_gap  output  1 each  one-cycle timing-violation strobes.
REQ-013 err_flags  output  3  sticky {gap, pulse, setup} violation flags.
REQ-014 clr_err  input  1  clears err_flags.
REQ-015 set_x  input  1  load x from x_val.
REQ-016 x_val  input  X_BITS signed  load value.
REQ-017 x  output  X_BITS signed  decoded position.
REQ-018 hold  input  1  capture x into x_hold.
REQ-019 x_hold  output  X_BITS signed  captured position.

Function
REQ-020 step_in and dir_in SHALL each pass a 2-FF synchronizer (s1, s2) plus a third delay stage s3 for edge detection.
REQ-021 Rise = s2 & !s3; fall = !s2 & s3; step_stb SHALL be registered, asserting in the cycle after the 3rd rising clk edge sampling step_in high (latency 3 cycles).
REQ-022 step_dir SHALL equal synchronized dir ^ invert_dir, registered and updated every cycle.
REQ-023 On rise: x <= x-1 if decoded dir = 1, else x+1; wraps modulo 2^X_BITS.
REQ-024 FSM states LOW and HIGH; LOW->HIGH on rise, HIGH->LOW on fall; no other transitions.
REQ-025 dir_age (16-bit) SHALL reset to 0 when synchronized dir changes, else increment, saturating at 16'hFFFF.
REQ-026 On rise, if dir_age < setup_n[15:0], err_setup SHALL pulse with step_stb; step still counted.
REQ-027 high_cnt SHALL load 1 on rise and increment in HIGH, saturating; on fall, if high_cnt < pulse_n[15:0], err_pulse pulses.
REQ-028 low_cnt SHALL load 1 on fall and increment in LOW, saturating; on rise, if low_cnt < gap_n[15:0], err_gap pulses; step still counted.
REQ-029 A dir change while in HIGH SHALL set err_setup strobe in that cycle (dir must be held through pulse).
REQ-030 Each err strobe SHALL set its err_flags bit; clr_err clears all bits; a same-cycle strobe wins over clr_err.
REQ-031 hold SHALL capture x as registered before any same-cycle update.
REQ-032 set_x SHALL override a same-cycle step update; x <= x_val.
REQ-033 setup_n/pulse_n/gap_n = 0 SHALL disable the respective check.

Reset
REQ-034 In reset: s1/s2/s3 = 0, state LOW, x = 0, x_hold = 0, step_stb = 0, step_dir = 0, all err outputs and err_flags = 0.
REQ-035 In reset: dir_age = low_cnt = 16'hFFFF, high_cnt = 0, so first post-reset step raises no setup/gap error.
REQ-036 reset SHALL override set_x, hold, clr_err and any pulse in progress; a step_in already high at reset release produces no step_stb until a new rise.

Verification
REQ-037 Reset, dir_in=0, setup/pulse/gap=4/4/4, step_in high 6 cycles -> one step_stb 3 cycles after, x=1, no errors.
REQ-038 dir_in=1 held 10 cycles, invert_dir=1, one step -> step_dir=0, x increments by 1.
REQ-039 dir_in toggled 2 cycles before step_in rise, setup_n=5 -> err_setup with step_stb, err_flags=3'b001, x still updated.
REQ-040 step_in high 2 cycles, pulse_n=4 -> err_pulse 1 cycle after synchronized fall; clr_err -> err_flags=0.
REQ-041 x=-1 (all ones), set_x with x_val=100 in same cycle as step_stb -> x=100; hold same cycle -> x_hold=-1.
REQ-042 x = 2^(X_BITS-1)-1, one forward step -> x = -2^(X_BITS-1).
